gfx_raster_engine: RTL and testbench

//  Parametrised successor to the rectangle fill/blit processor: draws one axis-aligned

---
 rtl/gfx_pkg.sv | 24 ++
 rtl/gfx_addr_gen.sv | 101 ++++++++++
 rtl/gfx_raster_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_gfx_raster_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg
//   Shared definitions for the rectangle raster engine: command opcodes,
//   the control FSM state encoding and a small opcode helper.
package gfx_pkg;

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_BLIT  = 2'b01;
    localparam logic [1:0] OP_KEYED = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Both blit flavours read the sprite ROM and go through the delay line.
    function automatic logic is_blit(input logic [1:0] op);
        return (op == OP_BLIT) || (op == OP_KEYED);
    endfunction

endpackage

// File: rtl/gfx_addr_gen.sv
// gfx_addr_gen
//   Raster-order scan generator for one clipped rectangle. Holds the x/y
//   scan counters, the VRAM row-base accumulator (steps by H_RES) and the
//   sprite source-address accumulator (steps by the unclipped source width).
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     load            initialise all counters at the top-left corner
//     step            advance one pixel in raster order
//     tl_x, tl_y      top-left corner of the rectangle
//     cbx, cby        clipped bottom-right corner (inclusive)
//     sw              source row pitch (width before clipping)
//     rom_base        ROM address of the sprite's first pixel
//     pix_addr        VRAM address of the current pixel
//     src_addr        ROM address of the current pixel
//     last_col        current pixel is the last visible one of its row
//     last_pix        current pixel is the last one of the rectangle
module gfx_addr_gen #(
    parameter int H_RES      = 640,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int ADDR_W     = 19,
    parameter int ROM_ADDR_W = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [X_W-1:0]        tl_x,
    input  logic [Y_W-1:0]        tl_y,
    input  logic [X_W:0]          cbx,
    input  logic [Y_W:0]          cby,
    input  logic [ROM_ADDR_W-1:0] sw,
    input  logic [ROM_ADDR_W-1:0] rom_base,
    output logic [ADDR_W-1:0]     pix_addr,
    output logic [ROM_ADDR_W-1:0] src_addr,
    output logic                  last_col,
    output logic                  last_pix
);

    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

    // One extra bit on x/y so that comparing against the clip corner at the
    // screen edge can never wrap.
    logic [X_W:0]          x_q, x_d;
    logic [Y_W:0]          y_q, y_d;
    logic [ADDR_W-1:0]     row_base_q, row_base_d;
    logic [ROM_ADDR_W-1:0] src_row_q, src_row_d;
    logic [ROM_ADDR_W-1:0] src_q, src_d;

    assign last_col = (x_q == cbx);
    assign last_pix = last_col && (y_q == cby);
    assign pix_addr = row_base_q + ADDR_W'(x_q);
    assign src_addr = src_q;

    // The only multiply is the one-off row base at load time; inside the scan
    // the row base and source row just add their pitch. Clipped-off columns
    // on the right are never visited, but the next source row still starts
    // a full SW after the previous one.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        src_row_d  = src_row_q;
        src_d      = src_q;
        if (load) begin
            x_d        = {1'b0, tl_x};
            y_d        = {1'b0, tl_y};
            row_base_d = ADDR_W'(tl_y) * H_STEP;
            src_row_d  = rom_base;
            src_d      = rom_base;
        end else if (step) begin
            if (last_col) begin
                x_d        = {1'b0, tl_x};
                y_d        = y_q + 1'b1;
                row_base_d = row_base_q + H_STEP;
                src_row_d  = src_row_q + sw;
                src_d      = src_row_q + sw;
            end else begin
                x_d   = x_q + 1'b1;
                src_d = src_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            src_row_q  <= '0;
            src_q      <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            src_row_q  <= src_row_d;
            src_q      <= src_d;
        end
    end

endmodule

// File: rtl/gfx_raster_engine.sv
// gfx_raster_engine
//   Draws one axis-aligned rectangle per command into frame-buffer VRAM at
//   one pixel per clock: solid fill, sprite ROM blit, or colour-keyed blit,
//   clipped to the right/bottom screen edges.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     start, opcode            command strobe (accepted only when idle), opcode
//     tl_x, tl_y, br_x, br_y   inclusive rectangle corners
//     arg                      fill colour or key colour
//     rom_base                 ROM address of the sprite's first pixel
//     rom_addr / rom_data      sprite ROM read port (ROM_LAT cycle latency)
//     vram_we/addr/data        VRAM write port, address = y*H_RES + x
//     busy, done, err          status: busy until done; err with done on a
//                              reserved opcode, held until the next start
module gfx_raster_engine #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 12,
    parameter int ROM_ADDR_W = 19,
    parameter int ROM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            opcode,
    input  logic [X_W-1:0]        tl_x,
    input  logic [Y_W-1:0]        tl_y,
    input  logic [X_W-1:0]        br_x,
    input  logic [Y_W-1:0]        br_y,
    input  logic [COLOR_W-1:0]    arg,
    input  logic [ROM_ADDR_W-1:0] rom_base,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [COLOR_W-1:0]    rom_data,
    output logic                  vram_we,
    output logic [ADDR_W-1:0]     vram_addr,
    output logic [COLOR_W-1:0]    vram_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import gfx_pkg::*;

    localparam int XW1     = X_W + 1;
    localparam int YW1     = Y_W + 1;
    localparam int DRAIN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [X_W:0]         X_MAX      = XW1'(H_RES - 1);
    localparam logic [Y_W:0]         Y_MAX      = YW1'(V_RES - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(ROM_LAT - 1);

    state_t state_q, state_d;

    logic [1:0]            op_q, op_d;
    logic [X_W-1:0]        tl_x_q, tl_x_d;
    logic [Y_W-1:0]        tl_y_q, tl_y_d;
    logic [X_W-1:0]        br_x_q, br_x_d;
    logic [Y_W-1:0]        br_y_q, br_y_d;
    logic [COLOR_W-1:0]    arg_q, arg_d;
    logic [ROM_ADDR_W-1:0] rom_base_q, rom_base_d;
    logic                  err_q, err_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;

    logic [ROM_LAT-1:0]             dl_valid_q, dl_valid_d;
    logic [ROM_LAT-1:0][ADDR_W-1:0] dl_addr_q, dl_addr_d;

    logic [X_W:0]          cbx;
    logic [Y_W:0]          cby;
    logic [X_W:0]          sw_full;
    logic [ROM_ADDR_W-1:0] sw;
    logic                  empty;
    logic                  accept;
    logic                  issue;
    logic                  blit;
    logic [ADDR_W-1:0]     pix_addr;
    logic [ROM_ADDR_W-1:0] src_addr;
    logic                  last_col;
    logic                  last_pix;
    logic                  out_valid;
    logic                  key_hit;

    // Geometry derived from the latched command. The source pitch uses the
    // unclipped width so clipped sprites keep their row alignment.
    always_comb begin
        cbx     = ({1'b0, br_x_q} > X_MAX) ? X_MAX : {1'b0, br_x_q};
        cby     = ({1'b0, br_y_q} > Y_MAX) ? Y_MAX : {1'b0, br_y_q};
        sw_full = {1'b0, br_x_q} - {1'b0, tl_x_q} + XW1'(1);
        sw      = ROM_ADDR_W'(sw_full);
        empty   = ({1'b0, tl_x_q} > cbx) || ({1'b0, tl_y_q} > cby);
    end

    assign accept = (state_q == ST_IDLE) && start;
    assign issue  = (state_q == ST_RUN);
    assign blit   = is_blit(op_q);

    gfx_addr_gen #(
        .H_RES      (H_RES),
        .X_W        (X_W),
        .Y_W        (Y_W),
        .ADDR_W     (ADDR_W),
        .ROM_ADDR_W (ROM_ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_SETUP),
        .step     (issue),
        .tl_x     (tl_x_q),
        .tl_y     (tl_y_q),
        .cbx      (cbx),
        .cby      (cby),
        .sw       (sw),
        .rom_base (rom_base_q),
        .pix_addr (pix_addr),
        .src_addr (src_addr),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    // Command latch: inputs are only captured on acceptance, so anything the
    // controller does on the command pins while busy has no effect.
    always_comb begin
        op_d       = op_q;
        tl_x_d     = tl_x_q;
        tl_y_d     = tl_y_q;
        br_x_d     = br_x_q;
        br_y_d     = br_y_q;
        arg_d      = arg_q;
        rom_base_d = rom_base_q;
        if (accept) begin
            op_d       = opcode;
            tl_x_d     = tl_x;
            tl_y_d     = tl_y;
            br_x_d     = br_x;
            br_y_d     = br_y;
            arg_d      = arg;
            rom_base_d = rom_base;
        end
    end

    // Control FSM next-state. Blits spend ROM_LAT cycles in DRAIN so the last
    // ROM read can come back and be written; fills go straight to DONE.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    err_d   = 1'b0;
                end
            end
            ST_SETUP: begin
                if (op_q == OP_RSVD) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (empty) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_pix) begin
                    if (blit) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Delay line carrying the VRAM address and a valid flag alongside the ROM
    // read, so they emerge in the same cycle as the matching rom_data.
    always_comb begin
        dl_valid_d    = '0;
        dl_addr_d     = '0;
        dl_valid_d[0] = issue && blit;
        dl_addr_d[0]  = pix_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_addr_d[i]  = dl_addr_q[i-1];
        end
    end

    // Output mux. Everything is gated so the write port reads all-zero when
    // idle or in reset; fills write straight from the scan counters.
    always_comb begin
        rom_addr  = (issue && blit) ? src_addr : '0;
        out_valid = dl_valid_q[ROM_LAT-1];
        key_hit   = (op_q == OP_KEYED) && (rom_data == arg_q);
        vram_we   = 1'b0;
        vram_addr = '0;
        vram_data = '0;
        if (op_q == OP_FILL) begin
            if (issue) begin
                vram_we   = 1'b1;
                vram_addr = pix_addr;
                vram_data = arg_q;
            end
        end else if (out_valid) begin
            vram_we   = !key_hit;
            vram_addr = dl_addr_q[ROM_LAT-1];
            vram_data = rom_data;
        end
        busy = (state_q == ST_SETUP) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done = (state_q == ST_DONE);
        err  = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_FILL;
            tl_x_q     <= '0;
            tl_y_q     <= '0;
            br_x_q     <= '0;
            br_y_q     <= '0;
            arg_q      <= '0;
            rom_base_q <= '0;
            err_q      <= 1'b0;
            drain_q    <= '0;
            dl_valid_q <= '0;
            dl_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tl_x_q     <= tl_x_d;
            tl_y_q     <= tl_y_d;
            br_x_q     <= br_x_d;
            br_y_q     <= br_y_d;
            arg_q      <= arg_d;
            rom_base_q <= rom_base_d;
            err_q      <= err_d;
            drain_q    <= drain_d;
            dl_valid_q <= dl_valid_d;
            dl_addr_q  <= dl_addr_d;
        end
    end

endmodule

// File: tb/tb_gfx_raster_engine.sv
// tb_gfx_raster_engine
//   Directed bench for the raster engine with a two-cycle sprite ROM model.
//   Every VRAM write is captured and compared with hand-computed addresses
//   and colours, along with command latency and status flags.
module tb_gfx_raster_engine;

   localparam int ROM_LAT = 2;
   localparam logic [1:0] OP_FILL  = 2'b00;
   localparam logic [1:0] OP_BLIT  = 2'b01;
   localparam logic [1:0] OP_KEYED = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  opcode;
   logic [9:0]  tl_x, br_x;
   logic [8:0]  tl_y, br_y;
   logic [11:0] arg;
   logic [18:0] rom_base;
   logic [18:0] rom_addr;
   logic [11:0] rom_data;
   logic        vram_we;
   logic [18:0] vram_addr;
   logic [11:0] vram_data;
   logic        busy, done, err;

   always #5 clk = ~clk;

   gfx_raster_engine #(.ROM_LAT(ROM_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode),
      .tl_x(tl_x), .tl_y(tl_y), .br_x(br_x), .br_y(br_y),
      .arg(arg), .rom_base(rom_base), .rom_addr(rom_addr), .rom_data(rom_data),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
      .busy(busy), .done(done), .err(err)
   );

   // Sprite ROM model: rom[i] = i, except that the keyed test plants the key
   // colour at addresses 2 and 5. Two register stages give the read latency.
   logic        romKeyed = 1'b0;
   logic [11:0] romPipe1 = '0, romPipe2 = '0;

   function automatic logic [11:0] romValue(input logic [18:0] a);
      if (romKeyed && (a == 19'd2 || a == 19'd5)) return 12'hF0F;
      return a[11:0];
   endfunction

   always @(posedge clk) begin
      romPipe1 <= romValue(rom_addr);
      romPipe2 <= romPipe1;
   end
   assign rom_data = romPipe2;

   // Capture every VRAM write away from the active edge.
   logic [18:0] wrAddr[$];
   logic [11:0] wrData[$];
   always @(negedge clk) begin
      if (vram_we) begin
         wrAddr.push_back(vram_addr);
         wrData.push_back(vram_data);
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Issue one command and count negedges until done. Optionally re-pulse
   // start with a garbage command at cycle pokeAt while the engine is busy.
   task automatic applyStimulus(input string tag, input logic [1:0] op,
                                input int tlx, input int tly, input int brx, input int bry,
                                input logic [11:0] a, input int base, input int pokeAt,
                                output int cycles, output logic errAtDone, output logic busyEarly);
      wrAddr.delete();
      wrData.delete();
      @(negedge clk);
      opcode   = op;
      tl_x     = 10'(tlx);
      tl_y     = 9'(tly);
      br_x     = 10'(brx);
      br_y     = 9'(bry);
      arg      = a;
      rom_base = 19'(base);
      start    = 1'b1;
      cycles    = 0;
      errAtDone = 1'b0;
      busyEarly = 1'b0;
      while (cycles < 20000) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            start     = 1'b0;
            busyEarly = busy;
         end
         if (cycles == pokeAt) begin
            start  = 1'b1;
            opcode = OP_RSVD;
            tl_x   = 10'd0;
            br_x   = 10'd639;
            arg    = 12'h123;
         end
         if (cycles == pokeAt + 1) start = 1'b0;
         if (done) begin
            errAtDone = err;
            break;
         end
      end
      checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   int          cyc;
   logic        errD, busyE;
   int          bad;
   int          expA[8];
   int          expD[8];

   initial begin
      rst = 1'b1; start = 1'b0; opcode = '0; tl_x = '0; tl_y = '0;
      br_x = '0; br_y = '0; arg = '0; rom_base = '0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst_vram_we", 32'(vram_we), 0);
      checkOutput("rst_vram_addr", 32'(vram_addr), 0);
      checkOutput("rst_vram_data", 32'(vram_data), 0);
      checkOutput("rst_rom_addr", 32'(rom_addr), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_err", 32'(err), 0);
      rst = 1'b0;
      @(negedge clk);

      // Full-width band fill of the bottom ten rows: consecutive addresses
      applyStimulus("band", OP_FILL, 0, 470, 639, 479, 12'h555, 0, -1, cyc, errD, busyE);
      checkOutput("band_cycles", 32'(cyc), 6402);
      checkOutput("band_count", 32'(wrAddr.size()), 6400);
      checkOutput("band_busy", 32'(busyE), 1);
      bad = 0;
      for (int i = 0; i < wrAddr.size(); i++)
         if (wrAddr[i] != 19'(300800 + i) || wrData[i] != 12'h555) bad++;
      checkOutput("band_bad_writes", 32'(bad), 0);

      // Small fill
      applyStimulus("fill", OP_FILL, 10, 5, 12, 6, 12'hABC, 0, -1, cyc, errD, busyE);
      checkOutput("fill_cycles", 32'(cyc), 8);
      checkOutput("fill_count", 32'(wrAddr.size()), 6);
      expA = '{3210, 3211, 3212, 3850, 3851, 3852, 0, 0};
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("fill_addr%0d", i), 32'(wrAddr[i]), 32'(expA[i]));
         checkOutput($sformatf("fill_data%0d", i), 32'(wrData[i]), 32'h0ABC);
      end

      // Plain blit, rom[i] = i
      applyStimulus("blit", OP_BLIT, 100, 100, 103, 101, 12'h000, 0, -1, cyc, errD, busyE);
      checkOutput("blit_cycles", 32'(cyc), 12);
      checkOutput("blit_count", 32'(wrAddr.size()), 8);
      expA = '{64100, 64101, 64102, 64103, 64740, 64741, 64742, 64743};
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("blit_addr%0d", i), 32'(wrAddr[i]), 32'(expA[i]));
         checkOutput($sformatf("blit_data%0d", i), 32'(wrData[i]), 32'(i));
      end

      // Keyed blit: key colour at rom[2] and rom[5] leaves 64102 and 64741 alone
      romKeyed = 1'b1;
      applyStimulus("keyed", OP_KEYED, 100, 100, 103, 101, 12'hF0F, 0, -1, cyc, errD, busyE);
      romKeyed = 1'b0;
      checkOutput("keyed_cycles", 32'(cyc), 12);
      checkOutput("keyed_count", 32'(wrAddr.size()), 6);
      expA = '{64100, 64101, 64103, 64740, 64742, 64743, 0, 0};
      expD = '{0, 1, 3, 4, 6, 7, 0, 0};
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("keyed_addr%0d", i), 32'(wrAddr[i]), 32'(expA[i]));
         checkOutput($sformatf("keyed_data%0d", i), 32'(wrData[i]), 32'(expD[i]));
      end

      // Clipped blit at the bottom-right corner; source rows advance by 63
      applyStimulus("clip", OP_BLIT, 638, 478, 700, 500, 12'h000, 0, -1, cyc, errD, busyE);
      checkOutput("clip_cycles", 32'(cyc), 8);
      checkOutput("clip_count", 32'(wrAddr.size()), 4);
      expA = '{306558, 306559, 307198, 307199, 0, 0, 0, 0};
      expD = '{0, 1, 63, 64, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("clip_addr%0d", i), 32'(wrAddr[i]), 32'(expA[i]));
         checkOutput($sformatf("clip_data%0d", i), 32'(wrData[i]), 32'(expD[i]));
      end

      // Empty rectangle (tl_x > br_x)
      applyStimulus("empty", OP_FILL, 20, 0, 10, 0, 12'h111, 0, -1, cyc, errD, busyE);
      checkOutput("empty_cycles", 32'(cyc), 2);
      checkOutput("empty_count", 32'(wrAddr.size()), 0);
      checkOutput("empty_err", 32'(errD), 0);

      // Reserved opcode
      applyStimulus("rsvd", OP_RSVD, 0, 0, 3, 3, 12'h222, 0, -1, cyc, errD, busyE);
      checkOutput("rsvd_cycles", 32'(cyc), 2);
      checkOutput("rsvd_count", 32'(wrAddr.size()), 0);
      checkOutput("rsvd_err", 32'(errD), 1);
      @(negedge clk);
      checkOutput("rsvd_err_held", 32'(err), 1);

      // Start pulsed while busy with garbage inputs: ignored; err cleared
      applyStimulus("poke", OP_FILL, 10, 5, 12, 6, 12'hABC, 0, 3, cyc, errD, busyE);
      checkOutput("poke_cycles", 32'(cyc), 8);
      checkOutput("poke_count", 32'(wrAddr.size()), 6);
      checkOutput("poke_err", 32'(errD), 0);
      bad = 0;
      for (int i = 0; i < wrAddr.size(); i++)
         if (wrData[i] != 12'hABC) bad++;
      checkOutput("poke_bad_data", 32'(bad), 0);
      checkOutput("poke_last_addr", 32'(wrAddr[5]), 3852);

      // Reset in the middle of a fill
      @(negedge clk);
      opcode = OP_FILL; tl_x = 10'd0; tl_y = 9'd0; br_x = 10'd639; br_y = 9'd479;
      arg = 12'h777; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      checkOutput("mid_we_before", 32'(vram_we), 1);
      rst = 1'b1;
      #1;
      checkOutput("mid_we_after_rst", 32'(vram_we), 0);
      checkOutput("mid_busy_after_rst", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus("after_rst", OP_FILL, 10, 5, 12, 6, 12'hABC, 0, -1, cyc, errD, busyE);
      checkOutput("after_rst_cycles", 32'(cyc), 8);
      checkOutput("after_rst_count", 32'(wrAddr.size()), 6);
      checkOutput("after_rst_first", 32'(wrAddr[0]), 3210);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
